// File: rtl/dmem_arbiter.sv
// Two-port word arbiter in front of the single-port data memory.
// CPU MEM stage and debug/loader port share the memory through a
// three-state sequencer (IDLE -> ISSUE -> RESP) with round-robin priority.
// CNT_RST_VAL sets the value the conflict counter resets to.
module dmem_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MEM_BYTES   = 32,
    parameter logic [15:0] CNT_RST_VAL = 16'h0000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_ack_o,
    output logic              cpu_err_o,
    output logic              cpu_stall_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              dbg_ack_o,
    output logic              dbg_err_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [15:0]       conflict_cnt_o
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;
    typedef enum logic {OWN_CPU = 1'b0, OWN_DBG = 1'b1} owner_t;

    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 4);

    state_t            r_state;
    state_t            w_next_state;
    owner_t            r_owner;
    owner_t            r_last_owner;
    logic              r_we;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_dbg_rdata;
    logic [15:0]       r_conflict_cnt;

    owner_t            w_grant;
    logic              w_any_req;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_sel_err;
    logic              w_ack;
    logic              w_rd_ok;

    // Arbitration, address check and next-state selection
    always_comb begin
        w_any_req    = cpu_req_i | dbg_req_i;
        w_grant      = OWN_CPU;
        w_next_state = r_state;
        if (dbg_req_i && (!cpu_req_i || r_last_owner == OWN_CPU)) begin
            w_grant = OWN_DBG;
        end
        w_sel_we    = (w_grant == OWN_DBG) ? dbg_we_i    : cpu_we_i;
        w_sel_addr  = (w_grant == OWN_DBG) ? dbg_addr_i  : cpu_addr_i;
        w_sel_wdata = (w_grant == OWN_DBG) ? dbg_wdata_i : cpu_wdata_i;
        w_sel_err   = (w_sel_addr[1:0] != 2'b00) || (w_sel_addr > MAX_ADDR);
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_next_state = w_sel_err ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: w_next_state = S_RESP;
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Memory strobe, per-port ack/err/rdata and pipeline stall
    always_comb begin
        mem_en_o    = (r_state == S_ISSUE) && !rst_i;
        mem_we_o    = mem_en_o && r_we;
        mem_addr_o  = r_addr;
        mem_wdata_o = r_wdata;
        w_ack       = (r_state == S_RESP) && !rst_i;
        w_rd_ok     = w_ack && !r_we && !r_err;
        cpu_ack_o   = w_ack && (r_owner == OWN_CPU);
        dbg_ack_o   = w_ack && (r_owner == OWN_DBG);
        cpu_err_o   = cpu_ack_o && r_err;
        dbg_err_o   = dbg_ack_o && r_err;
        // Read data is forwarded during the ack cycle, then held from the register.
        cpu_rdata_o = (w_rd_ok && r_owner == OWN_CPU) ? mem_rdata_i : r_cpu_rdata;
        dbg_rdata_o = (w_rd_ok && r_owner == OWN_DBG) ? mem_rdata_i : r_dbg_rdata;
        cpu_stall_o = cpu_req_i && !cpu_ack_o;
        conflict_cnt_o = r_conflict_cnt;
    end

    // State register, request latch, round-robin history, read capture, conflict count
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state        <= S_IDLE;
            r_owner        <= OWN_CPU;
            r_last_owner   <= OWN_DBG;
            r_we           <= 1'b0;
            r_err          <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_cpu_rdata    <= '0;
            r_dbg_rdata    <= '0;
            r_conflict_cnt <= CNT_RST_VAL;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_IDLE && w_any_req) begin
                r_owner <= w_grant;
                r_we    <= w_sel_we;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
                r_err   <= w_sel_err;
                if (cpu_req_i && dbg_req_i && w_grant == OWN_DBG &&
                    r_conflict_cnt != 16'hFFFF) begin
                    r_conflict_cnt <= r_conflict_cnt + 16'd1;
                end
            end
            if (r_state == S_RESP) begin
                r_last_owner <= r_owner;
                if (!r_we && !r_err) begin
                    if (r_owner == OWN_CPU) r_cpu_rdata <= mem_rdata_i;
                    else                    r_dbg_rdata <= mem_rdata_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a registered-read memory model.
// A second instance with the conflict counter reset to 0xFFFE shares all inputs
// and is used for the saturation check.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata;
    logic        cpu_ack, cpu_err, cpu_stall, dbg_ack, dbg_err, mem_en, mem_we;
    logic [15:0] cnt;
    logic [31:0] mem_rdata;

    logic [31:0] s_cpu_rdata, s_dbg_rdata, s_mem_addr, s_mem_wdata;
    logic        s_cpu_ack, s_cpu_err, s_cpu_stall, s_dbg_ack, s_dbg_err, s_mem_en, s_mem_we;
    logic [15:0] s_cnt;

    logic [31:0] mem [8];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_rdata_o(cpu_rdata), .cpu_ack_o(cpu_ack), .cpu_err_o(cpu_err), .cpu_stall_o(cpu_stall),
        .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
        .dbg_rdata_o(dbg_rdata), .dbg_ack_o(dbg_ack), .dbg_err_o(dbg_err),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .conflict_cnt_o(cnt)
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(32), .CNT_RST_VAL(16'hFFFE)) dut_sat (
        .clk_i(clk), .rst_i(rst),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_rdata_o(s_cpu_rdata), .cpu_ack_o(s_cpu_ack), .cpu_err_o(s_cpu_err), .cpu_stall_o(s_cpu_stall),
        .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
        .dbg_rdata_o(s_dbg_rdata), .dbg_ack_o(s_dbg_ack), .dbg_err_o(s_dbg_err),
        .mem_en_o(s_mem_en), .mem_we_o(s_mem_we), .mem_addr_o(s_mem_addr), .mem_wdata_o(s_mem_wdata),
        .mem_rdata_i(mem_rdata), .conflict_cnt_o(s_cnt)
    );

    // Single-port memory with registered read data
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[4:2]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[4:2]];
        end
    end

    typedef struct {
        logic        dbg;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_stall;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    endtask

    // Issue one access at a negedge, observe until ack (bounded), drop req after ack.
    task automatic access(input logic dbg, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output logic err,
                          output logic [31:0] rdata, output int stall_cnt, output int en_cnt,
                          output int other_ack, output logic mem_ok, output logic ack_after);
        lat = 0; err = 1'b0; rdata = '0; en_cnt = 0; other_ack = 0; mem_ok = 1'b1;
        if (dbg) begin dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; end
        else     begin cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; end
        #1;
        stall_cnt = int'(cpu_stall);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            stall_cnt += int'(cpu_stall);
            if (mem_en) begin
                en_cnt++;
                if (mem_we !== we || mem_addr !== addr || (we && mem_wdata !== wdata)) mem_ok = 1'b0;
            end
            if (dbg ? cpu_ack : dbg_ack) other_ack++;
            if (dbg ? dbg_ack : cpu_ack) begin
                lat   = k;
                err   = dbg ? dbg_err : cpu_err;
                rdata = dbg ? dbg_rdata : cpu_rdata;
                break;
            end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        ack_after = cpu_ack | dbg_ack;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int          lat, stall_cnt, en_cnt, other_ack, acks;
        logic        err, mem_ok, ack_after;
        logic [31:0] rdata;

        vecs[0] = '{1'b0, 1'b1, 32'h04, 32'h0000_0005, 1'b0, 32'h0000_0000, 2, 2};
        vecs[1] = '{1'b0, 1'b0, 32'h04, 32'h0,         1'b0, 32'h0000_0005, 2, 2};
        vecs[2] = '{1'b1, 1'b1, 32'h08, 32'h1122_3344, 1'b0, 32'h0000_0000, 2, 0};
        vecs[3] = '{1'b1, 1'b0, 32'h08, 32'h0,         1'b0, 32'h1122_3344, 2, 0};
        vecs[4] = '{1'b1, 1'b0, 32'h06, 32'h0,         1'b1, 32'h1122_3344, 1, 0};
        vecs[5] = '{1'b0, 1'b0, 32'h20, 32'h0,         1'b1, 32'h0000_0005, 1, 1};
        vecs[6] = '{1'b0, 1'b1, 32'h1C, 32'hA5A5_0001, 1'b0, 32'h0000_0005, 2, 2};
        vecs[7] = '{1'b0, 1'b0, 32'h1C, 32'h0,         1'b0, 32'hA5A5_0001, 2, 2};
        vecs[8] = '{1'b1, 1'b0, 32'h04, 32'h0,         1'b0, 32'h0000_0005, 2, 0};
        vecs[9] = '{1'b0, 1'b1, 32'h01, 32'hFFFF_FFFF, 1'b1, 32'hA5A5_0001, 1, 1};

        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        chk("rst_acks_errs", {28'h0, cpu_ack, cpu_err, dbg_ack, dbg_err}, 32'h0);
        chk("rst_mem_en_we", {30'h0, mem_en, mem_we}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_dbg_rdata", dbg_rdata, 32'h0);
        chk("rst_stall", {31'h0, cpu_stall}, 32'h0);
        chk("rst_conflict_cnt", {16'h0, cnt}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("first_idle_mem_en", {31'h0, mem_en}, 32'h0);

        for (int i = 0; i < 10; i++) begin
            access(vecs[i].dbg, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                   lat, err, rdata, stall_cnt, en_cnt, other_ack, mem_ok, ack_after);
            chk($sformatf("v%0d_ack_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_err", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
            chk($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d_stall_cycles", i), stall_cnt, vecs[i].exp_stall);
            chk($sformatf("v%0d_mem_en_cycles", i), en_cnt, vecs[i].exp_err ? 0 : 1);
            chk($sformatf("v%0d_other_port_ack", i), other_ack, 0);
            chk($sformatf("v%0d_mem_fields", i), {31'h0, mem_ok}, 32'h1);
            chk($sformatf("v%0d_ack_one_cycle", i), {31'h0, ack_after}, 32'h0);
        end

        // Simultaneous requests after reset: CPU first, then alternating.
        do_reset();
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h04;
            dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h08;
            acks = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (cpu_ack || dbg_ack) begin acks = 1; break; end
            end
            chk($sformatf("conflict%0d_acked", r), acks, 1);
            chk($sformatf("conflict%0d_winner_dbg", r), {31'h0, dbg_ack}, (r % 2 == 1) ? 32'h1 : 32'h0);
            chk($sformatf("conflict%0d_winner_cpu", r), {31'h0, cpu_ack}, (r % 2 == 0) ? 32'h1 : 32'h0);
            chk($sformatf("conflict%0d_rdata", r), (r % 2 == 0) ? cpu_rdata : dbg_rdata,
                (r % 2 == 0) ? 32'h0000_0005 : 32'h1122_3344);
            chk($sformatf("conflict%0d_cnt", r), {16'h0, cnt}, (r + 1) / 2);
            chk($sformatf("conflict%0d_sat_cnt", r), {16'h0, s_cnt}, (r == 0) ? 32'hFFFE : 32'hFFFF);
            @(negedge clk);
            idle_inputs();
        end

        // Reset while a CPU write sits in ISSUE.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h08; cpu_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("rstwr_in_issue", {31'h0, mem_en}, 32'h1);
        rst = 1'b1;
        #1;
        chk("rstwr_mem_en_forced", {31'h0, mem_en}, 32'h0);
        acks = 0;
        @(negedge clk);
        acks += int'(cpu_ack | dbg_ack);
        rst = 1'b0;
        idle_inputs();
        repeat (3) begin
            @(negedge clk);
            acks += int'(cpu_ack | dbg_ack);
        end
        chk("rstwr_no_ack", acks, 0);
        access(1'b0, 1'b0, 32'h08, 32'h0, lat, err, rdata, stall_cnt, en_cnt, other_ack, mem_ok, ack_after);
        chk("rstwr_readback_lat", lat, 2);
        chk("rstwr_readback", rdata, 32'h1122_3344);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data memory between the CPU MEM stage and a debug/loader port. It serialises word accesses, runs a 3-state access sequencer, and drives `cpu_stall_o` to freeze the pipeline while a CPU access is pending. It also keeps a saturating conflict counter that the bench reports alongside stall and flush counts. It sits between the MEM stage and `Data_Memory`; the memory itself is unchanged except that its read data is registered.

## Interface
- `ADDR_W`, 32, byte address width
- `DATA_W`, 32, word width; all accesses are whole words
- `MEM_BYTES`, 32, memory size in bytes; valid addresses are 0 .. MEM_BYTES-4
- `clk_i` in 1: the single clock
- `rst_i` in 1: reset, synchronous and active-high
- `cpu_req_i` in 1: CPU access request, held until `cpu_ack_o`
- `cpu_we_i` in 1: 1 = write, 0 = read
- `cpu_addr_i` in ADDR_W: byte address
- `cpu_wdata_i` in DATA_W: write data
- `cpu_rdata_o` out DATA_W: read data, valid with `cpu_ack_o`, held until the next CPU ack
- `cpu_ack_o` out 1: one-cycle completion pulse
- `cpu_err_o` out 1: qualifies `cpu_ack_o`; the access was misaligned or out of range
- `cpu_stall_o` out 1: pipeline freeze
- `dbg_req_i`, `dbg_we_i`, `dbg_addr_i`, `dbg_wdata_i`, `dbg_rdata_o`, `dbg_ack_o`, `dbg_err_o`: debug port, same widths and rules as the CPU port
- `mem_en_o` out 1: memory access strobe
- `mem_we_o` out 1: memory write enable
- `mem_addr_o` out ADDR_W: memory byte address
- `mem_wdata_o` out DATA_W: memory write data, little-endian (byte 0 is bits 7:0)
- `mem_rdata_i` in DATA_W: registered read data, valid the cycle after `mem_en_o`
- `conflict_cnt_o` out 16: saturating count of cycles in which both ports requested in IDLE and the CPU lost

## Operation
- **States:** IDLE, ISSUE, RESP.
- **IDLE:**
  - If no request, stay in IDLE.
  - Otherwise pick an owner:
    - if only one port requests, it wins;
    - if both request, the port not granted last wins (round-robin `last_owner` register).
  - Latch owner, we, addr and wdata.
  - If the latched address has `addr[1:0]` != 0, or `addr` > MEM_BYTES-4, set the error flag and go to RESP with no memory access.
  - Otherwise go to ISSUE.
- **ISSUE:**
  - `mem_en_o`=1, with `mem_we_o`/`mem_addr_o`/`mem_wdata_o` taken from the latch.
  - Go to RESP.
- **RESP:**
  - Pulse the owner's `ack` for one cycle. `err` = error flag.
  - On a read without error, capture `mem_rdata_i` into the owner's `rdata`. Writes and errors leave `rdata` unchanged.
  - Update `last_owner`. Go to IDLE.
- **Outputs:** `mem_*` are decoded from state and latch. `mem_en_o` is forced to 0 while `rst_i`=1.
- **Stall:** `cpu_stall_o` = `cpu_req_i` & ~`cpu_ack_o` (combinational).
- **Conflict counter:** increments in IDLE when both `req` are high and dbg is granted. It holds at 0xFFFF.
- **Requester rules:** each requester holds req/we/addr/wdata stable until ack and drops req the cycle after ack. The latch protects in-flight transactions, so a req that drops early still completes and acks.

## Timing
- Valid access: req sampled high in IDLE at cycle t → `mem_en_o` at t+1 → ack at t+2 → back in IDLE at t+3. The next grant is sampled at t+3.
- Throughput: 1 access per 3 cycles.
- Error access: ack+err at t+1, no `mem_en_o`, next grant sampled at t+2.
- Reset (sync, takes effect at the clock edge):
  - state IDLE;
  - `last_owner` = DBG, so the CPU wins the first conflict;
  - all ack/err/stall-independent outputs 0;
  - `rdata` = 0;
  - `conflict_cnt_o` = 0.
- Reset mid-transaction: the access is dropped, no ack is produced, and a write in ISSUE is suppressed. Requesters re-issue.
- Simultaneous requests on the ack cycle: not arbitrated until the next IDLE.

## Test plan
- **Reset values:** hold `rst_i` 2 cycles → all outputs 0, and the first idle cycle shows `mem_en_o`=0.
- **CPU write then read:** CPU writes 0x00000005 to 0x04, then reads 0x04 → `mem_en_o`/`mem_we_o` at t+1, ack at t+2, `cpu_rdata_o`=0x00000005. `cpu_stall_o` is high for exactly 2 cycles per access.
- **Simultaneous requests:** CPU and dbg both request from IDLE after reset → CPU is granted first, dbg second. Repeating 4 times alternates ownership, and `conflict_cnt_o` ends at 2.
- **Error cases:** dbg read of 0x06 → `dbg_ack_o`+`dbg_err_o` at t+1, no `mem_en_o`. CPU read of 0x20 → `cpu_err_o`, and `cpu_rdata_o` is unchanged.
- **Reset during a write:** assert `rst_i` while in ISSUE for a CPU write of 0xDEADBEEF to 0x08 → no write reaches memory, no ack, and a subsequent read of 0x08 returns the old value.
- **Counter saturation:** force a dbg-wins conflict repeatedly with the counter preloaded to 0xFFFE → reads 0xFFFF and stays there.
